mult_div_unit: RTL and testbench

Iterative multiply/divide unit for the MIPS datapath. It sits directly downstream of the register file and consumes the two read ports (rs → operandA, rt → operandB) when the decoder issues MULT/MULTU/DIV/DIVU. It holds the architectural HI/LO registers, which are written on completion or by MTHI/MTLO, and read by MFHI/MFLO.

---
 rtl/mult_div_pkg.sv | 26 ++
 rtl/add_sub33.sv | 12 +
 rtl/mult_div_unit.sv | 158 +++++++++++++++
 tb/tb_mult_div_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds op and state encodings, iteration count and helpers.
package mult_div_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int          ITERATIONS        = 32;
    localparam logic [4:0]  LAST_COUNT        = 5'(ITERATIONS - 1);
    localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFFFFFF;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/add_sub33.sv
// 33-bit adder/subtractor shared by multiply accumulate and divide trial.
// Ports: i_a, i_b operands; i_sub selects a-b; o_sum 33-bit result.
module add_sub33 (
    input  logic [32:0] i_a,
    input  logic [32:0] i_b,
    input  logic        i_sub,
    output logic [32:0] o_sum
);

    assign o_sum = i_a + (i_b ^ {33{i_sub}}) + {32'd0, i_sub};

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Ports: clk, reset, start/op/operandA/operandB launch an op;
// hiWrite/loWrite/writeData for MTHI/MTLO; busy, done, divByZero, hi, lo.
module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             hiWrite,
    input  logic             loWrite,
    input  logic [WIDTH-1:0] writeData,
    output logic             busy,
    output logic             done,
    output logic             divByZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e      r_state;
    logic [4:0]  r_count;
    logic        r_is_div;
    logic        r_sign_q;
    logic        r_sign_r;
    logic        r_dbz;
    logic [31:0] r_orig_a;
    logic [31:0] r_mcand;
    logic [31:0] r_acc_hi;
    logic [31:0] r_acc_lo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_zero;

    logic        w_op_div;
    logic        w_op_signed;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [32:0] w_add_a;
    logic [32:0] w_sum;
    logic [32:0] w_mul_acc;
    logic        w_take;
    logic [31:0] w_rem_next;
    logic [63:0] w_prod;
    logic [63:0] w_prod_fix;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    assign w_op_div    = (op == OP_DIV) || (op == OP_DIVU);
    assign w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_abs_a     = w_op_signed ? abs32(operandA) : operandA;
    assign w_abs_b     = w_op_signed ? abs32(operandB) : operandB;

    // Divide: shifted remainder {rem, quo[31]}; multiply: {0, P_hi}.
    assign w_add_a = r_is_div ? {r_acc_hi, r_acc_lo[31]}
                              : {1'b0, r_acc_hi};

    add_sub33 u_add_sub33 (
        .i_a   (w_add_a),
        .i_b   ({1'b0, r_mcand}),
        .i_sub (r_is_div),
        .o_sum (w_sum)
    );

    assign w_mul_acc  = r_acc_lo[0] ? w_sum : {1'b0, r_acc_hi};
    assign w_take     = ~w_sum[32];
    assign w_rem_next = w_take ? w_sum[31:0]
                               : {r_acc_hi[30:0], r_acc_lo[31]};

    assign w_prod     = {r_acc_hi, r_acc_lo};
    assign w_prod_fix = r_sign_q ? (64'd0 - w_prod) : w_prod;
    assign w_quo_fix  = r_sign_q ? (32'd0 - r_acc_lo) : r_acc_lo;
    assign w_rem_fix  = r_sign_r ? (32'd0 - r_acc_hi) : r_acc_hi;

    // Divide by zero reports the dividend as originally supplied.
    assign w_res_hi = !r_is_div ? w_prod_fix[63:32] :
                      r_dbz     ? r_orig_a : w_rem_fix;
    assign w_res_lo = !r_is_div ? w_prod_fix[31:0] :
                      r_dbz     ? DIV_ZERO_QUOTIENT : w_quo_fix;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= 5'd0;
            r_is_div   <= 1'b0;
            r_sign_q   <= 1'b0;
            r_sign_r   <= 1'b0;
            r_dbz      <= 1'b0;
            r_orig_a   <= 32'd0;
            r_mcand    <= 32'd0;
            r_acc_hi   <= 32'd0;
            r_acc_lo   <= 32'd0;
            r_hi       <= 32'd0;
            r_lo       <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (hiWrite) r_hi <= writeData;
                    if (loWrite) r_lo <= writeData;
                    if (start) begin
                        r_is_div <= w_op_div;
                        r_sign_q <= w_op_signed &
                                    (operandA[31] ^ operandB[31]);
                        r_sign_r <= w_op_signed & operandA[31];
                        r_dbz    <= w_op_div & (operandB == 32'd0);
                        r_orig_a <= operandA;
                        r_mcand  <= w_op_div ? w_abs_b : w_abs_a;
                        r_acc_hi <= 32'd0;
                        r_acc_lo <= w_op_div ? w_abs_a : w_abs_b;
                        r_count  <= 5'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_rem_next;
                        r_acc_lo <= {r_acc_lo[30:0], w_take};
                    end else begin
                        r_acc_hi <= w_mul_acc[32:1];
                        r_acc_lo <= {w_mul_acc[0], r_acc_lo[31:1]};
                    end
                    r_count <= r_count + 5'd1;
                    if (r_count == LAST_COUNT) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    r_hi       <= w_res_hi;
                    r_lo       <= w_res_lo;
                    r_done     <= 1'b1;
                    r_div_zero <= r_dbz;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign divByZero = r_div_zero;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic        hiWrite;
    logic        loWrite;
    logic [31:0] writeData;
    logic        busy;
    logic        done;
    logic        divByZero;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .operandA  (operandA),
        .operandB  (operandB),
        .hiWrite   (hiWrite),
        .loWrite   (loWrite),
        .writeData (writeData),
        .busy      (busy),
        .done      (done),
        .divByZero (divByZero),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic ref_model(input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, output logic [31:0] eh,
                             output logic [31:0] el, output logic ed);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ed = 1'b0;
        eh = 32'd0;
        el = 32'd0;
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                eh = p[63:32];
                el = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                eh = p[63:32];
                el = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    eh = a;
                    el = 32'hFFFFFFFF;
                    ed = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
        endcase
    endtask

    // Launch: returns at the negedge right after the start edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        op       = o;
        operandA = a;
        operandB = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    // n counts edges after the start edge; done must appear at 33.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("latency", n, 33);
    endtask

    task automatic run_check(input string nm, input logic [1:0] o,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] eh, input logic [31:0] el,
                             input logic ed);
        int n;
        issue(o, a, b);
        wait_done(0, n);
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
        check({nm, "_dbz"}, {31'd0, divByZero}, {31'd0, ed});
        check({nm, "_busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({nm, "_dbz_pulse"}, {31'd0, divByZero}, 32'd0);
    endtask

    initial begin
        int n;
        int saw;
        logic [1:0]  ro;
        logic [31:0] ra, rb, eh, el;
        logic        ed;

        reset     = 1'b1;
        start     = 1'b0;
        op        = 2'b00;
        operandA  = 32'd0;
        operandB  = 32'd0;
        hiWrite   = 1'b0;
        loWrite   = 1'b0;
        writeData = 32'd0;

        tbl[0] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
                   32'hFFFFFFFE, 32'h00000001, 1'b0};
        tbl[1] = '{2'b00, 32'hFFFFFFFD, 32'h00000007,
                   32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[2] = '{2'b00, 32'h80000000, 32'h80000000,
                   32'h40000000, 32'h00000000, 1'b0};
        tbl[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002,
                   32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[4] = '{2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0};
        tbl[5] = '{2'b10, 32'h80000000, 32'hFFFFFFFF,
                   32'h00000000, 32'h80000000, 1'b0};
        tbl[6] = '{2'b11, 32'd100, 32'd0,
                   32'h00000064, 32'hFFFFFFFF, 1'b1};
        tbl[7] = '{2'b10, 32'hFFFFFFF9, 32'd0,
                   32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};

        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dbz", {31'd0, divByZero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a,
                      tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dbz);
        end

        // Start and MTHI while busy are both dropped.
        issue(2'b01, 32'd5, 32'd6);
        repeat (5) @(negedge clk);
        op        = 2'b11;
        operandA  = 32'd9;
        operandB  = 32'd3;
        start     = 1'b1;
        hiWrite   = 1'b1;
        writeData = 32'h0000DEAD;
        @(negedge clk);
        start   = 1'b0;
        hiWrite = 1'b0;
        wait_done(6, n);
        check("ign_hi", hi, 32'd0);
        check("ign_lo", lo, 32'd30);
        @(negedge clk);
        check("ign_no_restart", {31'd0, busy}, 32'd0);
        loWrite   = 1'b1;
        writeData = 32'h00001234;
        @(negedge clk);
        loWrite = 1'b0;
        check("mtlo_lo", lo, 32'h00001234);
        check("mtlo_hi", hi, 32'd0);

        // MTHI together with start lands first, then result overwrites.
        hiWrite   = 1'b1;
        writeData = 32'h0000DEAD;
        op        = 2'b01;
        operandA  = 32'd2;
        operandB  = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        hiWrite = 1'b0;
        check("sim_wr_hi", hi, 32'h0000DEAD);
        wait_done(0, n);
        check("sim_res_hi", hi, 32'd0);
        check("sim_res_lo", lo, 32'd6);
        @(negedge clk);

        hiWrite   = 1'b1;
        loWrite   = 1'b1;
        writeData = 32'hCAFEF00D;
        @(negedge clk);
        hiWrite = 1'b0;
        loWrite = 1'b0;
        check("both_hi", hi, 32'hCAFEF00D);
        check("both_lo", lo, 32'hCAFEF00D);

        // Reset mid-divide aborts with no done.
        issue(2'b10, 32'd1000, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) saw++;
        end
        check("abort_no_done", saw, 0);
        run_check("post_rst", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);

        // New start accepted in the done cycle.
        issue(2'b01, 32'd7, 32'd8);
        wait_done(0, n);
        check("b2b_first_lo", lo, 32'd56);
        issue(2'b11, 32'd100, 32'd7);
        wait_done(0, n);
        check("b2b_hi", hi, 32'd2);
        check("b2b_lo", lo, 32'd14);
        @(negedge clk);

        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = $urandom_range(1, 15);
                2: rb = 32'hFFFFFFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
            ref_model(ro, ra, rb, eh, el, ed);
            run_check($sformatf("rnd%0d", i), ro, ra, rb, eh, el, ed);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
